// File: rtl/montmul_pipe.sv
// Pipelined Montgomery multiplier: c = a*b*2^-WIDTH mod Q over LANES lanes per beat.
// Three register stages (product, reduction terms, result); a single global advance enables all stages.
module montmul_pipe #(
    parameter int WIDTH = 16,
    parameter int Q     = 3329,
    parameter int QINV  = -3327,
    parameter int LANES = 1,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    input  logic                   in_mode,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_c,
    output logic [TAG_W-1:0]       out_tag,
    output logic [CNT_W-1:0]       done_cnt
);

    localparam int PW = 2 * WIDTH;
    localparam logic signed [PW-1:0]    Q_EXT  = PW'(Q);
    localparam logic signed [WIDTH-1:0] Q_W    = WIDTH'(Q);
    localparam logic [WIDTH-1:0]        QINV_W = WIDTH'(QINV);

    logic             en;
    logic             v1_reg;
    logic             v2_reg;
    logic             mode1_reg;
    logic             mode2_reg;
    logic [TAG_W-1:0] tag1_reg;
    logic [TAG_W-1:0] tag2_reg;

    // Every stage moves together; bubbles are not squeezed out during a stall.
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_reg    <= 1'b0;
            v2_reg    <= 1'b0;
            out_valid <= 1'b0;
            mode1_reg <= 1'b0;
            mode2_reg <= 1'b0;
            tag1_reg  <= '0;
            tag2_reg  <= '0;
            out_tag   <= '0;
        end else if (en) begin
            v1_reg    <= in_valid;
            v2_reg    <= v1_reg;
            out_valid <= v2_reg;
            mode1_reg <= in_mode;
            mode2_reg <= mode1_reg;
            tag1_reg  <= in_tag;
            tag2_reg  <= tag1_reg;
            out_tag   <= tag2_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_cnt <= '0;
        end else if (out_valid && out_ready) begin
            done_cnt <= done_cnt + CNT_W'(1);
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [PW-1:0]    a_ext;
        logic signed [PW-1:0]    b_ext;
        logic signed [PW-1:0]    prod1_reg;
        logic signed [PW-1:0]    prod2_reg;
        logic signed [PW-1:0]    tq2_reg;
        logic [WIDTH-1:0]        m_lo;
        logic signed [WIDTH-1:0] t_s;
        logic signed [PW-1:0]    t_ext;
        logic signed [PW-1:0]    diff;
        logic [WIDTH-1:0]        diff_lo_unused;
        logic signed [WIDTH-1:0] r_s;
        logic signed [WIDTH-1:0] c_next;
        logic signed [WIDTH-1:0] c_reg;

        assign a_ext = {{WIDTH{in_a[gi*WIDTH+WIDTH-1]}}, in_a[gi*WIDTH +: WIDTH]};
        assign b_ext = {{WIDTH{in_b[gi*WIDTH+WIDTH-1]}}, in_b[gi*WIDTH +: WIDTH]};

        // Only the low WIDTH bits of prod*QINV matter; t is their signed reading.
        assign m_lo  = prod1_reg[WIDTH-1:0] * QINV_W;
        assign t_s   = $signed(m_lo);
        assign t_ext = {{WIDTH{t_s[WIDTH-1]}}, t_s};

        // The low half of the difference is zero by construction.
        assign diff           = prod2_reg - tq2_reg;
        assign diff_lo_unused = diff[WIDTH-1:0];
        assign r_s            = $signed(diff[PW-1:WIDTH]);

        always_comb begin
            c_next = r_s;
            if (mode2_reg && (r_s < 0)) begin
                c_next = r_s + Q_W;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                prod1_reg <= '0;
                prod2_reg <= '0;
                tq2_reg   <= '0;
                c_reg     <= '0;
            end else if (en) begin
                prod1_reg <= a_ext * b_ext;
                prod2_reg <= prod1_reg;
                tq2_reg   <= t_ext * Q_EXT;
                c_reg     <= c_next;
            end
        end

        assign out_c[gi*WIDTH +: WIDTH] = c_reg;
    end

endmodule

// File: tb/tb_montmul_pipe.sv
// Bench for montmul_pipe: directed cases plus a random backpressured stream
// checked against an integer-arithmetic Montgomery model and an in-order scoreboard.
module tb_montmul_pipe;

    localparam int W     = 16;
    localparam int L     = 4;
    localparam int TW    = 4;
    localparam int CW    = 16;
    localparam int Q     = 3329;
    localparam int QINV  = -3327;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid;
    logic            in_ready;
    logic [L*W-1:0]  in_a;
    logic [L*W-1:0]  in_b;
    logic            in_mode;
    logic [TW-1:0]   in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [L*W-1:0]  out_c;
    logic [TW-1:0]   out_tag;
    logic [CW-1:0]   done_cnt;

    always #5 clk = ~clk;

    montmul_pipe #(
        .WIDTH(W), .Q(Q), .QINV(QINV), .LANES(L), .TAG_W(TW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c(out_c), .out_tag(out_tag), .done_cnt(done_cnt)
    );

    typedef struct {
        logic [L*W-1:0] c;
        logic [TW-1:0]  tag;
        int             cyc;
    } exp_t;

    exp_t            sb[$];
    logic [W-1:0]    got_c[$];
    logic [TW-1:0]   got_t[$];
    int              la[L];
    int              lb[L];
    int              n_pass = 0;
    int              n_chk  = 0;
    int              cyc    = 0;
    int              n_acc  = 0;
    int              n_fire = 0;
    bit              chk_lat = 1'b0;
    bit              prev_stall = 1'b0;
    logic [L*W-1:0]  prev_c;
    logic [TW-1:0]   prev_tag;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    endtask

    // c = (p - t*Q) / 2^W with t = centred (p*QINV mod 2^W); exact division.
    function automatic logic [W-1:0] mont(input int a, input int b, input bit mode);
        longint p, t, r;
        p = longint'(a) * longint'(b);
        t = (p * longint'(QINV)) & 64'hFFFF;
        if (t >= 32768) t = t - 65536;
        r = (p - t * longint'(Q)) / 65536;
        if (mode && r < 0) r = r + Q;
        return r[W-1:0];
    endfunction

    task automatic pack();
        for (int i = 0; i < L; i++) begin
            in_a[i*W +: W] = W'(la[i]);
            in_b[i*W +: W] = W'(lb[i]);
        end
    endtask

    // One clock cycle: sample at the falling edge, then return 1 time unit past the rising edge.
    task automatic tick();
        exp_t e;
        #4;
        if (in_valid && in_ready) begin
            e.tag = in_tag;
            e.cyc = cyc;
            for (int i = 0; i < L; i++) e.c[i*W +: W] = mont(la[i], lb[i], in_mode);
            sb.push_back(e);
            n_acc++;
        end
        if (prev_stall) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_c", 64'(out_c), 64'(prev_c));
            check("stall_tag", 64'(out_tag), 64'(prev_tag));
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                check("out_c", 64'(out_c), 64'(e.c));
                check("out_tag", 64'(out_tag), 64'(e.tag));
                if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'd3);
            end
            got_c.push_back(out_c[W-1:0]);
            got_t.push_back(out_tag);
            n_fire++;
        end
        prev_stall = out_valid && !out_ready;
        prev_c     = out_c;
        prev_tag   = out_tag;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input int a, input int b, input bit m, input int tg);
        for (int i = 0; i < L; i++) begin
            la[i] = a;
            lb[i] = b;
        end
        pack();
        in_mode  = m;
        in_tag   = TW'(tg);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_done_cnt", 64'(done_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        prev_stall = 1'b0;
        n_fire = 0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        int a0, f0, guard;
        in_valid = 1'b0; in_mode = 1'b0; in_tag = '0; in_a = '0; in_b = '0;
        out_ready = 1'b1;
        for (int i = 0; i < L; i++) begin la[i] = 0; lb[i] = 0; end
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_c", 64'(out_c), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_done_cnt", 64'(done_cnt), 64'd0);
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // T1-T3: unstalled directed beats, latency checked
        chk_lat = 1'b1;
        got_c.delete(); got_t.delete();
        send(1, 1, 1'b0, 1);
        idle(4);
        check("t1_one_one", 64'(got_c[0]), 64'd169);
        send(2285, 5, 1'b0, 2);
        send(0, 1234, 1'b0, 5);
        idle(4);
        check("t2_rmodq", 64'(got_c[1]), 64'd5);
        check("t2_zero", 64'(got_c[2]), 64'd0);
        got_c.delete(); got_t.delete();
        send(-1, 1, 1'b0, 3);
        send(-1, 1, 1'b1, 10);
        idle(4);
        check("t3_count", 64'(got_c.size()), 64'd2);
        check("t3_signed", 64'(got_c[0]), 64'hFF57);
        check("t3_tag0", 64'(got_t[0]), 64'h3);
        check("t3_canon", 64'(got_c[1]), 64'd3160);
        check("t3_tag1", 64'(got_t[1]), 64'hA);
        chk_lat = 1'b0;

        // T5: fill the pipe under backpressure, then release
        out_ready = 1'b0;
        send(7, 11, 1'b0, 4);
        send(-100, 33, 1'b1, 5);
        send(3000, -2, 1'b0, 6);
        check("t5_in_ready_full", 64'(in_ready), 64'd0);
        send(9, 9, 1'b0, 7);
        check("t5_in_ready_held", 64'(in_ready), 64'd0);
        check("t5_accepted", 64'(sb.size()), 64'd3);
        f0 = n_fire;
        out_ready = 1'b1;
        in_valid = 1'b0;
        repeat (3) tick();
        check("t5_burst", 64'(n_fire - f0), 64'd3);
        idle(3);

        // T4: 1000 random beats with random valid and backpressure
        do_reset();
        a0 = n_acc;
        guard = 0;
        while (((n_acc - a0) < 1000 || sb.size() > 0) && guard < 20000) begin
            for (int i = 0; i < L; i++) begin
                la[i] = int'($urandom_range(0, 2*Q - 2)) - (Q - 1);
                lb[i] = int'($urandom_range(0, 2*Q - 2)) - (Q - 1);
            end
            pack();
            in_mode   = 1'($urandom_range(0, 1));
            in_tag    = TW'($urandom_range(0, 15));
            in_valid  = ((n_acc - a0) < 1000) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            guard++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("t4_accepted", 64'(n_acc - a0), 64'd1000);
        check("t4_drained", 64'(sb.size()), 64'd0);
        check("t4_fired", 64'(n_fire), 64'd1000);
        check("t4_done_cnt", 64'(done_cnt), 64'd1000);

        // T6: reset with two beats in flight (one already presented)
        send(5, 6, 1'b0, 8);
        send(7, 8, 1'b0, 9);
        idle(1);
        check("t6_pre_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_cnt", 64'(done_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        prev_stall = 1'b0;
        check("t6_in_ready", 64'(in_ready), 64'd1);
        f0 = n_fire;
        got_c.delete(); got_t.delete();
        chk_lat = 1'b1;
        send(1, 1, 1'b0, 1);
        idle(6);
        check("t6_single", 64'(n_fire - f0), 64'd1);
        check("t6_value", 64'(got_c[0]), 64'd169);
        check("t6_done_cnt", 64'(done_cnt), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
